// File: rtl/fpcvt_int_xfer_pkg.sv
// rtl/fpcvt_int_xfer_pkg.sv - shared types and sizing for the FP-to-int result return stage
//
// Purpose : constants, queue entry type and pointer-width helper used by
//           fpcvt_int_xfer and fpcvt_xfer_fifo.
// Contents: LAT   - cycles from issue to result (in enabled cycles)
//           DEPTH - result queue entries (power of two, >= LAT)
//           TAGW  - destination tag width
//           PW    - queue pointer width (one extra wrap bit)
//           entry_t {data, alt, tag}

package fpcvt_int_xfer_pkg;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int TAGW  = 9;

  // Pointers carry one bit beyond the index so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PW = ptr_w(DEPTH);

  typedef struct packed {
    logic [63:0]     data;
    logic            alt;
    logic [TAGW-1:0] tag;
  } entry_t;

endpackage

// File: rtl/fpcvt_int_xfer_fifo.sv
// rtl/fpcvt_int_xfer_fifo.sv - result queue between conversion capture and integer writeback
//
// Purpose : DEPTH-entry FIFO of entry_t with wrap-bit pointers.
// Ports   : i_clk, i_rst      - clock, async active-high reset
//           i_wr_en, i_wr_entry - capture request and entry
//           i_rd_en          - pop request (ignored when empty)
//           o_head           - entry at read pointer
//           o_empty, o_full  - queue status
//           o_count          - occupied entries

module fpcvt_xfer_fifo
  import fpcvt_int_xfer_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  entry_t        i_wr_entry,
  input  logic          i_rd_en,
  output entry_t        o_head,
  output logic          o_empty,
  output logic          o_full,
  output logic [PW-1:0] o_count
);

  localparam int AW = PW - 1;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_do_rd;
  logic          w_do_wr;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // A write into a full queue is still legal when the head leaves the same
  // cycle: the freed slot is the one being written.
  assign w_do_rd = i_rd_en && !o_empty;
  assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_wr) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_wr_entry;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpcvt_int_xfer.sv
// rtl/fpcvt_int_xfer.sv - return stage re-tagging FP-to-int results for integer writeback
//
// Purpose : tracks issued conversions through a LAT-stage {valid, tag} pipe,
//           captures the lane result when it emerges, queues it and presents
//           it to writeback with valid/ready. Issue is credit-gated so the
//           queue never overflows under back-pressure.
// Option  : define FPCVT_XFER_BYPASS_EN to present a capture into an empty
//           queue combinationally when writeback is ready (saves one cycle).
// Ports   : i_clk, i_rst        - clock, async active-high reset
//           i_cvt_issue, i_cvt_tag, i_cvt_clken - issue side of the FP lane
//           i_cvt_res, i_cvt_alt - lane result, LAT enabled cycles after issue
//           o_issue_ok          - a new conversion may issue this cycle
//           o_wb_valid, i_wb_ready, o_wb_data, o_wb_tag, o_wb_alt - writeback
//           o_err_ovf           - sticky protocol error (bad issue or dropped result)

module fpcvt_int_xfer
  import fpcvt_int_xfer_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cvt_issue,
  input  logic [TAGW-1:0] i_cvt_tag,
  input  logic            i_cvt_clken,
  input  logic [63:0]     i_cvt_res,
  input  logic            i_cvt_alt,
  output logic            o_issue_ok,
  output logic            o_wb_valid,
  input  logic            i_wb_ready,
  output logic [63:0]     o_wb_data,
  output logic [TAGW-1:0] o_wb_tag,
  output logic            o_wb_alt,
  output logic            o_err_ovf
);

  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  logic [LAT-1:0]  r_pipe_vld;
  logic [TAGW-1:0] r_pipe_tag [LAT];
  logic            r_err_ovf;

  logic            w_capture;
  logic            w_bypass;
  logic            w_wr_en;
  logic            w_pop;
  logic            w_drop;
  logic            w_empty;
  logic            w_full;
  logic [PW-1:0]   w_count;
  logic [PW:0]     w_credit_used;
  entry_t          w_cap_entry;
  entry_t          w_head;

  // Latency pipe: frozen whenever the conversion unit is clock-gated, so an
  // issue presented while gated never enters it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_pipe_tag[i] <= '0;
      end
    end else if (i_cvt_clken) begin
      r_pipe_vld    <= {r_pipe_vld[LAT-2:0], i_cvt_issue};
      r_pipe_tag[0] <= i_cvt_tag;
      for (int i = 1; i < LAT; i++) begin
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  assign w_capture   = i_cvt_clken && r_pipe_vld[LAT-1];
  assign w_cap_entry = '{data: i_cvt_res, alt: i_cvt_alt, tag: r_pipe_tag[LAT-1]};

  // Credits count queued entries plus everything still in the pipe; a pop in
  // the current cycle is deliberately not credited to keep this registered-only.
  always_comb begin
    w_credit_used = {1'b0, w_count};
    for (int i = 0; i < LAT; i++) begin
      w_credit_used = w_credit_used + {{PW{1'b0}}, r_pipe_vld[i]};
    end
  end

  assign o_issue_ok = (w_credit_used < DEPTH_W);

`ifdef FPCVT_XFER_BYPASS_EN
  assign w_bypass = w_capture && w_empty && i_wb_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_wr_en = w_capture && !w_bypass;
  assign w_pop   = !w_empty && i_wb_ready;
  assign w_drop  = w_wr_en && w_full && !w_pop;

  fpcvt_xfer_fifo u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr_en    (w_wr_en),
    .i_wr_entry (w_cap_entry),
    .i_rd_en    (i_wb_ready),
    .o_head     (w_head),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_count    (w_count)
  );

  assign o_wb_valid = !w_empty || w_bypass;
  assign o_wb_data  = w_bypass ? w_cap_entry.data : w_head.data;
  assign o_wb_tag   = w_bypass ? w_cap_entry.tag  : w_head.tag;
  assign o_wb_alt   = w_bypass ? w_cap_entry.alt  : w_head.alt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_ovf <= 1'b0;
    end else if ((i_cvt_issue && (!o_issue_ok || !i_cvt_clken)) || w_drop) begin
      r_err_ovf <= 1'b1;
    end
  end

  assign o_err_ovf = r_err_ovf;

endmodule
